// File: rtl/regfile_param.sv
// Purpose: parametrised multi-port register file with optional zero register,
//          same-cycle write bypass and a one-entry-per-cycle scrub engine.
// Latency: reads are combinational; writes are visible through storage the
//          cycle after the accepting edge, or the same cycle through bypass.
// Backpressure: none; writes presented while scrubbing are dropped and
//          flagged by wr_drop on the following cycle.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   wr_en/addr/data     single write port
//   rd_addr/rd_data     NUM_RD packed read ports (port p at [p*W +: W])
//   clr_req             start a scrub (honoured only when idle)
//   clr_busy/clr_done   scrub in progress / one-cycle completion pulse
//   wr_drop             a write was discarded in the previous cycle
module regfile_param #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done,
  output logic                     wr_drop
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCRUB = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   mem_q [NUM_REGS];
  logic                wr_drop_q;

  logic                wr_in_range;
  logic                wr_zero;
  logic                wr_accept;

  // Compare at 32 bits so a power-of-two NUM_REGS does not make this a
  // constant-true comparison at ADDR_W bits.
  assign wr_in_range = 32'(wr_addr) < 32'(NUM_REGS);
  assign wr_zero     = ZERO_REG && (wr_addr == '0);
  assign wr_accept   = wr_en && (state_q != ST_SCRUB) && wr_in_range && !wr_zero;

  // Scrub sequencer: next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_SCRUB;
          idx_d   = '0;
        end
      end
      ST_SCRUB: begin
        if (idx_q == ADDR_W'(NUM_REGS - 1)) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wr_drop_q <= wr_en && (state_q == ST_SCRUB);
    end
  end

  // Storage: reset beats scrub, scrub beats write. Writes never land while
  // scrubbing anyway, so the last two never compete for the same entry.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rst) begin
        mem_q[i] <= '0;
      end else if ((state_q == ST_SCRUB) && (idx_q == ADDR_W'(i))) begin
        mem_q[i] <= '0;
      end else if (wr_accept && (wr_addr == ADDR_W'(i))) begin
        mem_q[i] <= wr_data;
      end
    end
  end

  // Read ports. wr_accept is already false during scrub, so bypass is
  // automatically suppressed there.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              ra_zero;
    logic              ra_oob;

    assign ra      = rd_addr[p*ADDR_W +: ADDR_W];
    assign ra_zero = ZERO_REG && (ra == '0);
    assign ra_oob  = 32'(ra) >= 32'(NUM_REGS);

    assign rd_data[p*DATA_W +: DATA_W] =
        (ra_zero || ra_oob)                   ? '0      :
        (BYPASS && wr_accept && wr_addr == ra) ? wr_data :
                                                mem_q[ra];
  end

  assign clr_busy = (state_q == ST_SCRUB);
  assign clr_done = (state_q == ST_DONE);
  assign wr_drop  = wr_drop_q;

endmodule

// File: tb/tb_regfile_param.sv
// Purpose: directed self-checking bench for regfile_param (default, no-bypass
//          and 6-entry/3-port instances sharing one write/scrub stimulus).
// Latency: inputs driven at the falling edge, outputs sampled 1 time unit later.
// Backpressure: n/a.
module tb_regfile_param;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        clr_req;
  logic [5:0]  rd_addr;
  logic [8:0]  rd_addr6;

  logic [31:0] rd_data;
  logic [31:0] rd_data_nb;
  logic [47:0] rd_data6;
  logic        busy, done, drop;
  logic        busy_nb, done_nb, drop_nb;
  logic        busy6, done6, drop6;

  int n_chk  = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  regfile_param dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .clr_req(clr_req), .clr_busy(busy), .clr_done(done), .wr_drop(drop)
  );

  regfile_param #(.BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_nb),
    .clr_req(clr_req), .clr_busy(busy_nb), .clr_done(done_nb), .wr_drop(drop_nb)
  );

  regfile_param #(.NUM_REGS(6), .NUM_RD(3)) dut6 (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr6), .rd_data(rd_data6),
    .clr_req(clr_req), .clr_busy(busy6), .clr_done(done6), .wr_drop(drop6)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [31:0] rm(input int p);
    return 32'(rd_data[p*16 +: 16]);
  endfunction

  function automatic logic [31:0] rnb(input int p);
    return 32'(rd_data_nb[p*16 +: 16]);
  endfunction

  function automatic logic [31:0] r6(input int p);
    return 32'(rd_data6[p*16 +: 16]);
  endfunction

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    clr_req = 1'b0; rd_addr = '0; rd_addr6 = '0;
    tick();
    tick();

    // Reset state
    rst = 1'b0;
    rd_addr = {3'd3, 3'd3};
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_drop", 32'(drop), 0);
    check("rst_rd3", rm(0), 0);
    tick();

    // Zero register ignores writes and reads 0
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hBEEF; rd_addr = {3'd0, 3'd0};
    #1;
    check("zero_wr_p0", rm(0), 0);
    check("zero_wr_p1", rm(1), 0);
    tick();

    // Write reg3: bypassed on main instance, old value without bypass
    wr_addr = 3'd3; wr_data = 16'h1234; rd_addr = {3'd3, 3'd3};
    #1;
    check("byp_r3_p0", rm(0), 32'h1234);
    check("nobyp_r3_p0", rnb(0), 0);
    tick();

    wr_en = 1'b0; rd_addr = {3'd0, 3'd3};
    #1;
    check("r3_stored", rm(0), 32'h1234);
    check("r0_after", rm(1), 0);
    check("nobyp_r3_next", rnb(0), 32'h1234);
    tick();
    rd_addr = {3'd3, 3'd3};
    #1;
    check("r3_p1_agree", rm(1), 32'h1234);
    tick();

    // Bypass on both ports aliasing the same address
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'hA5A5; rd_addr = {3'd5, 3'd5};
    #1;
    check("byp_r5_p0", rm(0), 32'hA5A5);
    check("byp_r5_p1", rm(1), 32'hA5A5);
    check("nobyp_r5_p0", rnb(0), 0);
    check("nobyp_r5_p1", rnb(1), 0);
    tick();
    wr_en = 1'b0;
    #1;
    check("nobyp_r5_next_p0", rnb(0), 32'hA5A5);
    check("nobyp_r5_next_p1", rnb(1), 32'hA5A5);
    tick();

    // Fill regs 1..7 with k*0x1111; the 6-entry instance must ignore 6 and 7
    for (int k = 1; k <= 7; k++) begin
      wr_en = 1'b1; wr_addr = 3'(k); wr_data = 16'(k * 16'h1111);
      tick();
    end
    wr_en = 1'b0;
    rd_addr  = {3'd2, 3'd4};
    rd_addr6 = {3'd7, 3'd6, 3'd5};
    #1;
    check("fill_r4", rm(0), 32'h4444);
    check("fill_r2", rm(1), 32'h2222);
    check("six_r5", r6(0), 32'h5555);
    check("six_r6_oob", r6(1), 0);
    check("six_r7_oob", r6(2), 0);
    tick();

    // Scrub from cycle t (c = 0), with a dropped write to reg2 at c = 3
    for (int c = 0; c <= 10; c++) begin
      clr_req = (c == 0);
      wr_en   = (c == 3); wr_addr = 3'd2; wr_data = 16'hFFFF;
      #1;
      check($sformatf("scr_busy_c%0d", c), 32'(busy), 32'(c >= 1 && c <= 8));
      check($sformatf("scr_done_c%0d", c), 32'(done), 32'(c == 9));
      check($sformatf("scr_drop_c%0d", c), 32'(drop), 32'(c == 4));
      check($sformatf("scr_r4_c%0d", c), rm(0), (c <= 5) ? 32'h4444 : 32'h0);
      check($sformatf("scr_r2_c%0d", c), rm(1), (c <= 3) ? 32'h2222 : 32'h0);
      check($sformatf("nb_busy_c%0d", c), 32'(busy_nb), 32'(c >= 1 && c <= 8));
      check($sformatf("nb_done_c%0d", c), 32'(done_nb), 32'(c == 9));
      check($sformatf("nb_drop_c%0d", c), 32'(drop_nb), 32'(c == 4));
      check($sformatf("six_busy_c%0d", c), 32'(busy6), 32'(c >= 1 && c <= 6));
      check($sformatf("six_done_c%0d", c), 32'(done6), 32'(c == 7));
      check($sformatf("six_drop_c%0d", c), 32'(drop6), 32'(c == 4));
      check($sformatf("six_r5_c%0d", c), r6(0), (c <= 6) ? 32'h5555 : 32'h0);
      tick();
    end
    clr_req = 1'b0; wr_en = 1'b0;

    // Reset mid-scrub
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h1111;
    tick();
    wr_addr = 3'd6; wr_data = 16'h6666;
    tick();
    wr_en = 1'b0; rd_addr = {3'd6, 3'd1};
    #1;
    check("pre_r1", rm(0), 32'h1111);
    check("pre_r6", rm(1), 32'h6666);
    tick();
    for (int c = 0; c <= 12; c++) begin
      clr_req = (c == 0) || (c == 11);
      rst     = (c == 3);
      wr_en   = (c == 3); wr_addr = 3'd6; wr_data = 16'h9999;
      #1;
      check($sformatf("mid_busy_c%0d", c), 32'(busy), 32'((c >= 1 && c <= 3) || c == 12));
      check($sformatf("mid_done_c%0d", c), 32'(done), 0);
      check($sformatf("mid_drop_c%0d", c), 32'(drop), 0);
      check($sformatf("mid_r1_c%0d", c), rm(0), (c <= 2) ? 32'h1111 : 32'h0);
      check($sformatf("mid_r6_c%0d", c), rm(1), (c <= 3) ? 32'h6666 : 32'h0);
      tick();
    end
    rst = 1'b0; clr_req = 1'b0; wr_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
